// File: rtl/add16u_err_monitor.sv
// Error-statistics monitor for an approximate 16-bit unsigned adder (17-bit sum).
// Compares each sample against the exact sum and accumulates count, EP, MAE numerator and WCE.
module add16u_err_monitor #(
    parameter int unsigned N_SAMPLES = 65536,
    parameter int unsigned ACC_W     = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [16:0]      in_o,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [31:0]      sample_cnt,
    output logic [31:0]      err_cnt,
    output logic [ACC_W-1:0] err_sum,
    output logic [16:0]      wce,
    output logic [15:0]      wce_a,
    output logic [15:0]      wce_b
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int unsigned SUM_W = ((ACC_W > 17) ? ACC_W : 17) + 1;
    localparam logic [31:0] LAST = 32'(N_SAMPLES - 1);
    localparam logic [SUM_W-1:0] SAT = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    state_t      state;
    logic [31:0] acc_cnt;
    logic        s1_valid;
    logic [15:0] s1_a;
    logic [15:0] s1_b;
    logic [16:0] s1_o;
    logic [16:0] s1_exact;

    logic             accept;
    logic [16:0]      err;
    logic [SUM_W-1:0] sum_ext;
    logic [ACC_W-1:0] sum_next;

    // Sum is widened to hold both operands so saturation works even when ACC_W < 17.
    always_comb begin
        accept   = in_valid & in_ready;
        err      = (s1_o >= s1_exact) ? (s1_o - s1_exact) : (s1_exact - s1_o);
        sum_ext  = SUM_W'(err_sum) + SUM_W'(err);
        sum_next = (sum_ext > SAT) ? '1 : ACC_W'(sum_ext);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            acc_cnt    <= '0;
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_o       <= '0;
            s1_exact   <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            err_sum    <= '0;
            wce        <= '0;
            wce_a      <= '0;
            wce_b      <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_o     <= in_o;
                s1_exact <= {1'b0, in_a} + {1'b0, in_b};
            end

            if (s1_valid) begin
                sample_cnt <= sample_cnt + 32'd1;
                if (err != '0)
                    err_cnt <= err_cnt + 32'd1;
                err_sum <= sum_next;
                if (err > wce) begin
                    wce   <= err;
                    wce_a <= s1_a;
                    wce_b <= s1_b;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        acc_cnt    <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        sample_cnt <= '0;
                        err_cnt    <= '0;
                        err_sum    <= '0;
                        wce        <= '0;
                        wce_a      <= '0;
                        wce_b      <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 32'd1;
                        if (acc_cnt == LAST) begin
                            state    <= S_DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/add16u_err_monitor.md
# add16u_err_monitor

Sequential error-statistics monitor that sits directly downstream of an approximate 16-bit unsigned adder (add16u family, 17-bit sum output). It consumes the operand pair and the approximate sum for each sample, computes the exact sum internally, and accumulates characterisation metrics for one run: sample count, error count (EP), absolute-error sum (MAE numerator) and worst-case error (WCE) with the operands that produced it. It is used for on-FPGA characterisation of approximate adders against the exact reference.

## Interface
Parameters:
- N_SAMPLES, 65536: samples per run; legal range 1..2^32-1.
- ACC_W, 48: width of err_sum; legal range 4..64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle run request; acted on only in IDLE or DONE.
- in_valid  in  1  sample present on in_a/in_b/in_o.
- in_a  in  16  operand A given to the adder.
- in_b  in  16  operand B given to the adder.
- in_o  in  17  approximate sum produced by the adder for in_a/in_b.
- in_ready  out  1  sample accepted on an edge where in_valid & in_ready.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; held until the next start or reset.
- sample_cnt  out  32  samples accumulated.
- err_cnt  out  32  samples with in_o != in_a+in_b.
- err_sum  out  ACC_W  sum of absolute errors; saturates at all-ones.
- wce  out  17  largest absolute error seen.
- wce_a  out  16  in_a of the first sample reaching the current wce.
- wce_b  out  16  in_b of the same sample.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. The reset state is IDLE.
- IDLE and DONE: when start=1, clear all statistics outputs and the internal accept counter, then go to RUN.
- RUN: in_ready=1. On the edge that accepts the N_SAMPLES-th sample (accept counter == N_SAMPLES-1), go to DRAIN. No further samples are accepted.
- DRAIN: in_ready=0. Lasts exactly 1 cycle, then goes to DONE.
- DONE: done=1, in_ready=0, statistics frozen.
- start in RUN or DRAIN is ignored.
- Pipeline stage 1: on accept, register in_a, in_b, in_o, exact = {1'b0,in_a}+{1'b0,in_b} (17-bit) and a valid flag.
- Pipeline stage 2: err = |in_o - exact|, computed as a 17-bit unsigned magnitude (larger minus smaller).
  - sample_cnt += 1.
  - If err != 0: err_cnt += 1.
  - err_sum = min(err_sum + err, 2^ACC_W-1).
  - If err > wce (strict): wce = err, and wce_a/wce_b are captured. Ties keep the earlier operands.
- in_valid while in_ready=0 has no effect. Gaps in in_valid during RUN are allowed and do not add to any counter.
- Reset values: every output is 0, the pipeline valid flags are 0, and the state is IDLE.
- rst_n low in any state, including mid-run, has the same effect as reset on the next edge.

## Timing
- A sample accepted at edge k is in stage 1 after edge k. It is reflected in all statistics outputs after edge k+1.
- Nth accept at edge k: state is DRAIN after edge k. After edge k+1, state is DONE, done=1 and the statistics are final in the same cycle.
- in_ready falls in the cycle after the Nth accept. Because it is driven from the state register, there is no overshoot.
- start at edge j in IDLE/DONE: statistics read 0 and in_ready=1 after edge j. done falls after edge j.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with random inputs -> all outputs 0, in_ready=0, busy=0, done=0.
- Exact run, N_SAMPLES=4: feed four samples with in_o=in_a+in_b -> done=1 one cycle after the 4th accept; sample_cnt=4, err_cnt=0, err_sum=0, wce=0.
- Error mix, N_SAMPLES=4, feed these samples:
  - (1,1,0): error 2.
  - (5,3,9): error 1.
  - (0xFFFF,0xFFFF,0x1FFF5): error 9.
  - (2,2,4): error 0.
  - Required -> sample_cnt=4, err_cnt=3, err_sum=12, wce=9, wce_a=0xFFFF, wce_b=0xFFFF.
- Tie and backpressure, N_SAMPLES=3:
  - Stimulus: (10,0,15) then (0,10,5), both error 5, then one exact sample. in_valid is held high for 6 cycles with 1-cycle gaps inserted before the third sample.
  - Required: exactly 3 accepts, wce=5, wce_a=10, wce_b=0, in_ready low from the cycle after the 3rd accept.
- Saturation, ACC_W=4, N_SAMPLES=2: two samples of error 9 -> err_sum=15, err_cnt=2.
- Mid-run control: start pulsed in RUN -> no effect on counters. rst_n=0 after 2 of 4 samples -> IDLE, all outputs 0. A following start plus 4 samples completes normally.
